blink_pulse_driver: RTL and testbench
=====================================

Name: blink_pulse_driver

Overview:
- Output-side counterpart to the input debouncer.
- Takes single-cycle event pulses from internal logic and renders each one as a visible, fixed-length pulse on a slow external pin, such as an LED or buzzer enable.
- Each pulse is followed by a mandatory gap, so consecutive events stay distinguishable to a human.
- Events arriving while a pulse is in progress are queued in a saturating pending counter; a long-period clock-enable prescaler sets the time base.

Parameters:
TICK_PERIOD  32'd49999  prescaler terminal count; one tick every TICK_PERIOD+1 clocks
ON_TICKS  16'd100  active-pulse length in ticks; 0 treated as 1
OFF_TICKS  16'd100  gap length in ticks after each pulse; 0 treated as 1
PEND_MAX  4'd15  saturation value of the pending counter (1..15)
IDLE_LEVEL  1'b0  level of SIG_O when not pulsing; active level is ~IDLE_LEVEL

Ports:
CLK_O  input  1  system clock
RST  input  1  synchronous reset, active-high
PULSE_I  input  1  event request, one event per cycle high
CLR_I  input  1  synchronous abort/flush
SIG_O  output  1  driven pin level (registered)
BUSY_O  output  1  high while in ON or OFF state
PEND_O  output  4  queued events not yet started
OVF_O  output  1  sticky: an event was dropped at saturation
DONE_O  output  1  one-cycle pulse when a pulse+gap sequence completes

Behaviour:
- Interface: one clock, CLK_O. RST is synchronous and active-high.
- Reset (RST high at a CLK_O edge):
  - Outputs: SIG_O=IDLE_LEVEL, BUSY_O=0, PEND_O=0, OVF_O=0, DONE_O=0.
  - Internals: state=IDLE; prescaler and tick counter = 0.
  - RST has priority over CLR_I and PULSE_I, and applies mid-operation the same way.
- Prescaler:
  - 32-bit counter, cleared on every state entry.
  - tick = (prescaler==TICK_PERIOD); on tick the prescaler wraps to 0.
  - It counts only in ON/OFF; it is held at 0 in IDLE.
- Tick counter:
  - 16-bit, cleared on state entry, incremented on tick.
  - The state ends on the tick where count == N-1 (N = ON_TICKS or OFF_TICKS, clamped to ≥1).
  - So ON lasts exactly N*(TICK_PERIOD+1) cycles, and OFF likewise.
- State machine:
  - IDLE → ON when PEND_O != 0.
  - ON → OFF at end of ON.
  - OFF → ON at end of OFF if PEND_O != 0; else OFF → IDLE.
- Outputs by state:
  - SIG_O = ~IDLE_LEVEL exactly in ON, IDLE_LEVEL otherwise.
  - BUSY_O = (state != IDLE).
- Pending counter:
  - +1 on PULSE_I; −1 on every transition into ON; both in the same cycle → unchanged.
  - If the increment would exceed PEND_MAX with no simultaneous decrement, the count stays at PEND_MAX and OVF_O is set.
  - OVF_O is sticky until RST or CLR_I.
- Latency: PULSE_I high in cycle c, with state IDLE and PEND_O=0 → PEND_O=1 in c+1 → ON, SIG_O active, PEND_O=0 in c+2.
- DONE_O: high for exactly one cycle, the first cycle after an OFF state ends, whether the next state is IDLE or ON.
- CLR_I:
  - Next cycle: state=IDLE, SIG_O=IDLE_LEVEL, PEND_O=0, OVF_O=0, counters=0.
  - No DONE_O is produced.
  - A PULSE_I in the same cycle as CLR_I is discarded.

Test Plan:
Bench parameters: TICK_PERIOD=3, ON_TICKS=2, OFF_TICKS=1, PEND_MAX=3, IDLE_LEVEL=0.
1. Hold RST high 3 cycles, inputs toggling → SIG_O=0, BUSY_O=0, PEND_O=0, OVF_O=0, DONE_O=0 throughout and on release.
2. Single PULSE_I at cycle 0 → PEND_O=1 at cycle 1; SIG_O=1 cycles 2–9; SIG_O=0 and BUSY_O=1 cycles 10–13; DONE_O=1 only at cycle 14 with BUSY_O=0.
3. PULSE_I at cycles 0, 1, 2 → PEND_O 1,1,2; SIG_O=1 cycles 2–9, 14–21, 26–33; DONE_O at cycles 14, 26, 38; BUSY_O falls at cycle 38.
4. Six PULSE_I back-to-back starting at cycle 0 → PEND_O saturates at 3 and OVF_O=1 from cycle 5. OVF_O holds through all three remaining blinks until CLR_I.
5. At PEND_O=3, a PULSE_I in the cycle of the OFF→ON transition → PEND_O stays 3 and OVF_O does not newly set.
6. CLR_I together with PULSE_I at cycle 5, mid-ON, with PEND_O=2 → cycle 6: SIG_O=0, BUSY_O=0, PEND_O=0, OVF_O=0, no DONE_O; the output stays idle afterwards. Repeat the sequence using RST instead of CLR_I → same response.

Source files
------------

// File: rtl/blink_pulse_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blink_pulse_driver_if : event request / pin-status bundle for the blink driver
// Rev 1.0
// ---------------------------------------------------------------------------
interface blink_pulse_driver_if;
    logic       PULSE_I;
    logic       CLR_I;
    logic       SIG_O;
    logic       BUSY_O;
    logic [3:0] PEND_O;
    logic       OVF_O;
    logic       DONE_O;

    modport master (
        output PULSE_I, CLR_I,
        input  SIG_O, BUSY_O, PEND_O, OVF_O, DONE_O
    );

    modport slave (
        input  PULSE_I, CLR_I,
        output SIG_O, BUSY_O, PEND_O, OVF_O, DONE_O
    );
endinterface
`default_nettype wire

// File: rtl/blink_pulse_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// blink_pulse_driver : stretches event pulses into fixed ON/OFF blinks on a pin
// Rev 1.0
// ---------------------------------------------------------------------------
module blink_pulse_driver #(
    parameter logic [31:0] TICK_PERIOD = 32'd49999,
    parameter logic [15:0] ON_TICKS    = 16'd100,
    parameter logic [15:0] OFF_TICKS   = 16'd100,
    parameter logic [3:0]  PEND_MAX    = 4'd15,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic                  CLK_O,
    input  logic                  RST,
    blink_pulse_driver_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    // A zero length is clamped to one tick, so the last-tick index is 0.
    localparam logic [15:0] c_ON_LAST  = (ON_TICKS  == 16'd0) ? 16'd0 : ON_TICKS  - 16'd1;
    localparam logic [15:0] c_OFF_LAST = (OFF_TICKS == 16'd0) ? 16'd0 : OFF_TICKS - 16'd1;

    state_t      state_q, state_d;
    logic [31:0] presc_q, presc_d;
    logic [15:0] tcnt_q,  tcnt_d;
    logic [3:0]  pend_q,  pend_d;
    logic        ovf_q,   ovf_d;
    logic        done_q,  done_d;
    logic        sig_q,   sig_d;

    logic        w_tick;
    logic        w_last;
    logic        w_end;
    logic        w_enter_on;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        tcnt_d     = tcnt_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        sig_d      = IDLE_LEVEL;

        w_tick     = (state_q != ST_IDLE) && (presc_q == TICK_PERIOD);
        w_last     = (state_q == ST_ON) ? (tcnt_q == c_ON_LAST) : (tcnt_q == c_OFF_LAST);
        w_end      = w_tick && w_last;

        case (state_q)
            ST_IDLE: begin
                if (pend_q != 4'd0) state_d = ST_ON;
            end
            ST_ON: begin
                if (w_end) state_d = ST_OFF;
            end
            ST_OFF: begin
                if (w_end) begin
                    done_d  = 1'b1;
                    state_d = (pend_q != 4'd0) ? ST_ON : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        w_enter_on = (state_d == ST_ON) && (state_q != ST_ON);

        // Time base restarts on every state entry and idles at zero.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            presc_d = 32'd0;
            tcnt_d  = 16'd0;
        end else if (w_tick) begin
            presc_d = 32'd0;
            tcnt_d  = tcnt_q + 16'd1;
        end else begin
            presc_d = presc_q + 32'd1;
        end

        if (bus.PULSE_I && !w_enter_on) begin
            if (pend_q >= PEND_MAX) begin
                pend_d = PEND_MAX;
                ovf_d  = 1'b1;
            end else begin
                pend_d = pend_q + 4'd1;
            end
        end else if (!bus.PULSE_I && w_enter_on) begin
            pend_d = pend_q - 4'd1;
        end

        sig_d = (state_d == ST_ON) ? ~IDLE_LEVEL : IDLE_LEVEL;

        if (bus.CLR_I) begin
            state_d = ST_IDLE;
            presc_d = 32'd0;
            tcnt_d  = 16'd0;
            pend_d  = 4'd0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            sig_d   = IDLE_LEVEL;
        end
    end

    always_ff @(posedge CLK_O) begin
        if (RST) begin
            state_q <= ST_IDLE;
            presc_q <= 32'd0;
            tcnt_q  <= 16'd0;
            pend_q  <= 4'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            sig_q   <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            sig_q   <= sig_d;
        end
    end

    assign bus.SIG_O  = sig_q;
    assign bus.BUSY_O = (state_q != ST_IDLE);
    assign bus.PEND_O = pend_q;
    assign bus.OVF_O  = ovf_q;
    assign bus.DONE_O = done_q;

endmodule
`default_nettype wire

// File: tb/tb_blink_pulse_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_blink_pulse_driver : scoreboard bench against a cycle-countdown model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_blink_pulse_driver;

    localparam int TP       = 3;
    localparam int ONT      = 2;
    localparam int OFFT     = 1;
    localparam int PMAX     = 3;
    localparam int ON_LEN   = ONT  * (TP + 1);
    localparam int OFF_LEN  = OFFT * (TP + 1);

    logic clk;
    logic rst;
    logic pulse;
    logic clr;

    int checks   = 0;
    int failures = 0;

    blink_pulse_driver_if bif ();

    assign bif.PULSE_I = pulse;
    assign bif.CLR_I   = clr;

    blink_pulse_driver #(
        .TICK_PERIOD (32'd3),
        .ON_TICKS    (16'd2),
        .OFF_TICKS   (16'd1),
        .PEND_MAX    (4'd3),
        .IDLE_LEVEL  (1'b0)
    ) dut (
        .CLK_O (clk),
        .RST   (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       sig;
        logic       busy;
        logic [3:0] pend;
        logic       ovf;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    // Reference: 0 idle, 1 pulsing, 2 gap; m_rem counts clocks left in phase.
    int m_phase = 0;
    int m_rem   = 0;
    int m_pend  = 0;
    bit m_ovf   = 0;
    bit m_done  = 0;

    always @(posedge clk) begin
        exp_t e;
        bit   start_on;
        int   np;
        start_on = 0;
        m_done   = 0;
        if (rst || clr) begin
            m_phase = 0; m_rem = 0; m_pend = 0; m_ovf = 0;
        end else begin
            if (m_phase == 0) begin
                if (m_pend > 0) begin m_phase = 1; m_rem = ON_LEN; start_on = 1; end
            end else if (m_phase == 1) begin
                if (m_rem == 1) begin m_phase = 2; m_rem = OFF_LEN; end
                else m_rem = m_rem - 1;
            end else begin
                if (m_rem == 1) begin
                    m_done = 1;
                    if (m_pend > 0) begin m_phase = 1; m_rem = ON_LEN; start_on = 1; end
                    else begin m_phase = 0; m_rem = 0; end
                end else m_rem = m_rem - 1;
            end
            np = m_pend + int'(pulse) - int'(start_on);
            if (np > PMAX) begin np = PMAX; m_ovf = 1; end
            m_pend = np;
        end
        e.sig  = (m_phase == 1);
        e.busy = (m_phase != 0);
        e.pend = 4'(m_pend);
        e.ovf  = m_ovf;
        e.done = m_done;
        exp_q.push_back(e);
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("SIG_O",  {3'b0, bif.SIG_O},  {3'b0, e.sig});
            check("BUSY_O", {3'b0, bif.BUSY_O}, {3'b0, e.busy});
            check("PEND_O", bif.PEND_O,         e.pend);
            check("OVF_O",  {3'b0, bif.OVF_O},  {3'b0, e.ovf});
            check("DONE_O", {3'b0, bif.DONE_O}, {3'b0, e.done});
        end
    end

    // Bit i of each mask is the input level sampled at the i-th following edge.
    task automatic run_pattern(input logic [63:0] pm, input logic [63:0] cm,
                               input logic [63:0] rm, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse = pm[i];
            clr   = cm[i];
            rst   = rm[i];
        end
        @(negedge clk);
        pulse = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse = 1'b0; clr = 1'b0; rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; pulse = 1'b0; clr = 1'b0;
        // Reset held with other inputs toggling.
        run_pattern(64'h5, 64'h2, 64'h7, 3);
        idle(3);
        // Single event.
        run_pattern(64'h1, 64'h0, 64'h0, 1);
        idle(20);
        // Three consecutive events.
        run_pattern(64'h7, 64'h0, 64'h0, 3);
        idle(45);
        // Six events: saturation and sticky overflow, then flush.
        run_pattern(64'h3F, 64'h0, 64'h0, 6);
        idle(42);
        run_pattern(64'h0, 64'h1, 64'h0, 1);
        idle(3);
        // Event at a gap-to-pulse transition while the queue is full.
        run_pattern(64'h200F, 64'h0, 64'h0, 14);
        idle(45);
        // Abort mid-pulse with a simultaneous event, first CLR_I then RST.
        run_pattern(64'h27, 64'h20, 64'h0, 6);
        idle(20);
        run_pattern(64'h27, 64'h0, 64'h20, 6);
        idle(20);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pulse = ($urandom_range(0, 5) == 0);
            clr   = ($urandom_range(0, 199) == 0);
            rst   = ($urandom_range(0, 499) == 0);
        end
        idle(60);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 4'(exp_q.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
